// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, divider default, bit indices and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DIV_RATE_DEFAULT = 260;

  localparam logic [2:0] BIT_LSB = 3'd0;
  localparam logic [2:0] BIT_MSB = 3'd7;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial line in, status pulses and byte out.
interface uart_rx_if;
  logic       rx;
  logic       rx_busy;
  logic       rx_end;
  logic       rx_err;
  logic [7:0] rx_data;

  modport master (
    output rx,
    input  rx_busy,
    input  rx_end,
    input  rx_err,
    input  rx_data
  );

  modport slave (
    input  rx,
    output rx_busy,
    output rx_end,
    output rx_err,
    output rx_data
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with falling-edge detect for an asynchronous, idle-high pin.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= STOP_LVL;
      r_sync <= STOP_LVL;
      r_prev <= STOP_LVL;
    end else begin
      r_meta <= rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rx_s    = r_sync;
  assign rx_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled start/data/stop bits, one-cycle end/error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV_RATE = DIV_RATE_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(DIV_RATE + 1);
  localparam logic [CW-1:0] DIV_FULL = CW'(DIV_RATE);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV_RATE / 2);

  logic w_rx_s;
  logic w_rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (bus.rx),
    .rx_s    (w_rx_s),
    .rx_fall (w_rx_fall)
  );

  uart_state_e   r_state, w_state_nx;
  logic [CW-1:0] r_div, w_div_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_sh, w_sh_nx;
  logic [7:0]    r_data, w_data_nx;
  logic          r_end, w_end_nx;
  logic          r_err, w_err_nx;

  logic w_div_zero;
  assign w_div_zero = (r_div == '0);

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_bit_nx   = r_bit;
    w_sh_nx    = r_sh;
    w_data_nx  = r_data;
    w_end_nx   = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rx_fall) begin
          w_state_nx = START;
          w_div_nx   = DIV_HALF;
        end
      end
      START: begin
        if (w_div_zero) begin
          // A line already high at the start-bit centre was a glitch.
          if (w_rx_s == START_LVL) begin
            w_state_nx = DATA;
            w_div_nx   = DIV_FULL;
            w_bit_nx   = BIT_LSB;
          end else begin
            w_state_nx = IDLE;
          end
        end else begin
          w_div_nx = r_div - CW'(1);
        end
      end
      DATA: begin
        if (w_div_zero) begin
          w_sh_nx  = {w_rx_s, r_sh[7:1]};
          w_div_nx = DIV_FULL;
          if (r_bit == BIT_MSB) begin
            w_state_nx = STOP;
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end else begin
          w_div_nx = r_div - CW'(1);
        end
      end
      STOP: begin
        if (w_div_zero) begin
          // Leave at the stop-bit centre so a back-to-back start edge is still seen.
          w_state_nx = IDLE;
          if (w_rx_s == STOP_LVL) begin
            w_data_nx = r_sh;
            w_end_nx  = 1'b1;
          end else begin
            w_err_nx = 1'b1;
          end
        end else begin
          w_div_nx = r_div - CW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_bit   <= w_bit_nx;
      r_sh    <= w_sh_nx;
      r_data  <= w_data_nx;
      r_end   <= w_end_nx;
      r_err   <= w_err_nx;
    end
  end

  assign bus.rx_busy = (r_state != IDLE);
  assign bus.rx_end  = r_end;
  assign bus.rx_err  = r_err;
  assign bus.rx_data = r_data;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV_RATE=15: directed frames, glitch, break, reset abort, bulk stream.
module tb_uart_rx;
  localparam int unsigned D   = 15;
  localparam int unsigned BIT = D + 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if bus ();

  uart_rx #(.DIV_RATE(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with cycle count n; stop-sample edge is n+3+H+1+9*(D+1) = n+155.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t       e;
    logic [9:0] fr;
    int         n;
    n        = cyc;
    fr       = {stop, b, 1'b0};
    e.is_err = !stop;
    e.data   = stop ? b : last_good;
    e.cyc    = n + 155;
    q.push_back(e);
    if (stop) last_good = b;
    for (int k = 0; k < 10 * BIT; k++) begin
      bus.rx = fr[k / BIT];
      if (k == 2)   check("busy_before_t0", bus.rx_busy, 1'b0);
      if (k == 3)   check("busy_after_t0", bus.rx_busy, 1'b1);
      if (k == 154) check("busy_before_stop", bus.rx_busy, 1'b1);
      if (k == 155) check("busy_drop_at_stop", bus.rx_busy, 1'b0);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (bus.rx_end || bus.rx_err)) begin
      check("end_err_exclusive", bus.rx_end & bus.rx_err, 1'b0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: end=%0b err=%0b data=%0h, expected no pulse (cycle %0d)",
                 bus.rx_end, bus.rx_err, bus.rx_data, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind_err", bus.rx_err, mon_e.is_err);
        check("pulse_data", bus.rx_data, mon_e.data);
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    logic [7:0] ab;
    logic [9:0] afr;
    int         n;

    rst    = 1'b0;
    bus.rx = 1'b1;
    wait_neg(3);
    check("reset_busy", bus.rx_busy, 1'b0);
    check("reset_end", bus.rx_end, 1'b0);
    check("reset_err", bus.rx_err, 1'b0);
    check("reset_data", bus.rx_data, 8'h00);
    rst = 1'b1;
    wait_neg(10);

    send_frame(8'hA5, 1'b1);
    check("data_hold_a5", bus.rx_data, 8'hA5);
    wait_neg(20);

    // 5-clock low glitch: T0 = n+3, start sample at n+11 sees the line high again.
    n = cyc;
    bus.rx = 1'b0;
    wait_neg(2);
    check("glitch_busy_pre", bus.rx_busy, 1'b0);
    wait_neg(1);
    check("glitch_busy_rise", bus.rx_busy, 1'b1);
    wait_neg(2);
    bus.rx = 1'b1;
    wait_neg(5);
    check("glitch_busy_hold", bus.rx_busy, 1'b1);
    wait_neg(1);
    check("glitch_busy_drop", bus.rx_busy, 1'b0);
    check("glitch_cycle", cyc - n, 11);
    wait_neg(20);

    // Framing error followed by a held-low break line.
    send_frame(8'h3C, 1'b0);
    bus.rx = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) check("break_no_start", bus.rx_busy, 1'b0);
      @(negedge clk);
    end
    check("break_data_kept", bus.rx_data, 8'hA5);
    bus.rx = 1'b1;
    wait_neg(20);
    send_frame(8'h81, 1'b1);
    wait_neg(10);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_neg(10);

    // Reset pulse in the middle of bit 4 of an aborted frame.
    ab  = 8'h77;
    afr = {1'b1, ab, 1'b0};
    for (int k = 0; k < 5 * BIT + BIT / 2; k++) begin
      bus.rx = afr[k / BIT];
      @(negedge clk);
    end
    rst = 1'b0;
    wait_neg(1);
    check("abort_busy", bus.rx_busy, 1'b0);
    check("abort_end", bus.rx_end, 1'b0);
    check("abort_err", bus.rx_err, 1'b0);
    check("abort_data", bus.rx_data, 8'h00);
    rst       = 1'b1;
    bus.rx    = 1'b1;
    last_good = 8'h00;
    wait_neg(3 * BIT);
    check("abort_quiet", bus.rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    wait_neg(10);

    send_frame(8'h00, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
    end
    bus.rx = 1'b1;

    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    wait_neg(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the serial-to-parallel end of the 8N1 link whose transmitter shifts LSB-first at one bit per `DIV_RATE+1` clocks. Synchronises the asynchronous `rx` pin, detects the start bit, samples each bit at its centre and presents the received byte with a one-cycle completion strobe. It sits beside the transmitter in the UART peripheral and feeds the bus-side receive register and interrupt logic.

## Interface
- `DIV_RATE`, default 260: bit period is `DIV_RATE+1` clocks, the same value the transmitter uses; must be ≥ 3.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`; idle high.
- `rx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `rx_end`  out  1  one-cycle pulse: valid frame received, `rx_data` updated.
- `rx_err`  out  1  one-cycle pulse: framing error (stop bit sampled low).
- `rx_data`  out  8  last correctly received byte; held until the next valid frame.

## Operation
- Input path: 2-flop synchroniser, reset to 1, plus a previous-value flop, reset to 1. Falling edge = previous 1 and synchronised 0.
- States are IDLE, START, DATA and STOP. There is one down-counter `div_cnt` of width ceil(log2(DIV_RATE+1)), a 3-bit `bit_cnt` and an 8-bit shift register.
- IDLE: on a falling edge, go to START with `div_cnt` ← `DIV_RATE/2` (truncating). Otherwise stay in IDLE.
- START: decrement `div_cnt`. When `div_cnt==0`, sample the line.
  - Line 0: go to DATA, `div_cnt` ← `DIV_RATE`, `bit_cnt` ← 0.
  - Line 1 (false start / glitch): return to IDLE with no pulse.
- DATA: when `div_cnt==0`, do all of the following:
  - Shift right with the sampled bit entering bit 7, so the LSB arrives first.
  - Reload `div_cnt` ← `DIV_RATE`.
  - If `bit_cnt==7`, go to STOP; otherwise `bit_cnt` +1.
- STOP: when `div_cnt==0`, sample the line.
  - Line 1: `rx_data` ← shift register and pulse `rx_end`.
  - Line 0: pulse `rx_err` and leave `rx_data` unchanged.
  - Either way, return to IDLE at the stop-bit centre, so the next start edge is never missed.
- After a framing error caused by a held-low line (break), no new frame starts until the line has been seen high and then falls again.
- Reset asserted at any point, including mid-frame: state IDLE, counters 0, shift register 0, synchroniser flops 1, all outputs 0. The partial frame is discarded without a pulse.

## Timing
- Reset values: `rx_busy`=0, `rx_end`=0, `rx_err`=0, `rx_data`=8'h00.
- Synchroniser latency is 2 clocks. T0 is the clock edge at which the falling edge is detected, i.e. 2–3 clocks after `rx` falls. Let D = `DIV_RATE` and H = D/2.
- Sample edges:
  - Start bit: T0+H+1.
  - Data bit i (i = 0..7): T0+H+1+(i+1)(D+1).
  - Stop bit: T0+H+1+9(D+1).
- `rx_end`/`rx_err` and the new `rx_data` are registered on the stop-sample edge, visible for exactly the following cycle (pulse), with `rx_data` holding afterwards.
- `rx_busy` rises the cycle after T0 and falls together with the `rx_end`/`rx_err` pulse. A false start drops `rx_busy` after the start sample.
- `rx_end` and `rx_err` are never high together.
- No backpressure: the consumer must latch `rx_data` before the next `rx_end`, at least 9.5 bit periods later.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP) shared with the transmitter;
  - the default divider constant;
  - the bit-count constants (LSB index 0, MSB index 7);
  - the START/STOP bit levels (0/1).
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser plus falling-edge detector, with outputs `rx_s` and `rx_fall`. It is reusable for CTS and other asynchronous pins.
- The FSM, counters and shift register stay in `uart_rx`.

## Test plan
- D=15, drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) → `rx_end` pulses exactly once at T0+152, `rx_data`=8'hA5, `rx_err` stays 0.
- Low glitch of 5 clocks (< H+1) on idle line → no `rx_end`/`rx_err`; `rx_busy` high only until T0+8, then back to 0.
- Frame 0x3C with the stop bit driven 0 → `rx_err` pulses once, `rx_data` keeps its previous value, and no new frame starts until the line returns high.
- Back-to-back 0x00 then 0xFF with zero idle gap → two `rx_end` pulses exactly 10(D+1)=160 clocks apart, with data 0x00 then 0xFF.
- Reset pulsed low during bit 4 of a frame → all outputs 0 the next cycle, no pulse for the aborted frame, and the next full frame 0x5A is received correctly.
- Loopback from the UART transmitter at D=15, sending 0x00, 0x55, 0xAA, 0xFF and 256 random bytes → every byte is received unchanged and `rx_err` is never asserted.
